data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the core's load/store memory port; sits behind the memory stage and serves word-aligned loads and stores from a local word array.
- Replaces the zero-latency combinational data memory with a request/response handshake and configurable read latency.
- The hazard logic holds the memory stage while req_ready is low.

Parameters:
word_width, 32, data/address width in bits; must be a multiple of 8
depth_words, 1024, number of words in the array; power of two, at least 2
read_latency, 2, cycles from read acceptance edge to rsp_valid; at least 1
base_addr, 0, byte address mapped to word 0; aligned to depth_words*4

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_we  input  1  1 = store, 0 = load
req_addr  input  word_width  byte address
req_wdata  input  word_width  store data
req_wstrb  input  word_width/8  byte enables for stores; ignored for loads
req_ready  output  1  responder can accept a request this cycle
rsp_valid  output  1  single-cycle response pulse
rsp_rdata  output  word_width  load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or out of range; qualified by rsp_valid

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Array contents are not cleared.
- Acceptance: req_valid && req_ready at a rising edge. Request fields are sampled only at that edge.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; counts read latency.
  - RESP: rsp_valid=1 for exactly one cycle; req_ready=1.
- Address decode:
  - off = req_addr - base_addr, unsigned, word_width bits.
  - err = (req_addr[1:0] != 0) or (off >= depth_words*4).
  - Word index = off[clog2(depth_words)+1:2].
- Store, no error:
  - Array bytes with req_wstrb[i]=1 are written at the acceptance edge; other bytes are unchanged. wstrb=0 writes nothing and is still a legal request.
  - Next state RESP; response 1 cycle after acceptance, rsp_rdata=0, rsp_err=0.
- Load, no error:
  - Data is captured from the array at the acceptance edge into a holding register.
  - read_latency=1: next state RESP.
  - Otherwise: next state WAIT with counter=read_latency-1. WAIT decrements each cycle and moves to RESP when the counter reaches 1.
  - rsp_valid is high exactly read_latency cycles after the acceptance edge. rsp_rdata is the held word, rsp_err=0.
- Error, either direction:
  - Array is not modified.
  - Next state RESP after 1 cycle with rsp_err=1, rsp_rdata=0.
- In RESP:
  - If a new request is accepted, it is processed as from IDLE (back-to-back).
  - Otherwise the next state is IDLE.
  - Sustained throughput: one store or error per cycle; one load per read_latency cycles.
- Read-after-write: a load accepted any cycle after a store's acceptance edge returns the updated bytes.
- Outputs rsp_rdata and rsp_err are registered and hold 0 whenever rsp_valid=0.
- Reset mid-operation (WAIT or RESP): the pending response is dropped with no rsp_valid pulse. A store already accepted remains committed.
- req_valid while req_ready=0 is ignored. The requester must hold the request; the responder does not latch it.

Decomposition:
- Shared package mem_if_pkg holds:
  - typedef mem_state_t {IDLE, WAIT, RESP};
  - localparams for the strobe width (word_width/8) and index width (clog2(depth_words));
  - the function computing the error flag.
- One sub-module, byte_strobe_ram:
  - synchronous byte-strobed write port and read port with registered output;
  - the responder FSM, counter and decode stay in data_mem_responder.

Test Plan:
1. Reset mid-WAIT: issue a load with read_latency=3, assert reset 1 cycle after acceptance -> rsp_valid never pulses; after release req_ready=1 and all outputs are 0.
2. Store/load with read_latency=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> rsp_valid 1 cycle later, err=0, rdata=0. Then load 0x10 -> rsp_valid exactly 2 cycles after acceptance with rdata=0xDEADBEEF, and req_ready=0 during WAIT.
3. Byte strobes: store 0x11223344 to 0x20 with wstrb 0xF, then store 0xAABBCCDD with wstrb 0x5 -> a load of 0x20 returns 0x11BB33DD.
4. Errors:
   - load 0x22 (misaligned) -> rsp_err=1, rdata=0, 1 cycle later;
   - store 0x1000 with depth_words=1024 -> rsp_err=1, and a load of 0x0 is unchanged.
5. Back-to-back stores:
   - 4 consecutive stores with req_valid held high -> four rsp_valid pulses on consecutive cycles and req_ready never drops.
   - read_latency=1: alternating load/store streams at one request per cycle.
6. Base offset, base_addr=0x8000: store 0x8004 then load 0x8004 -> returns the stored data; a load of 0x0004 gives rsp_err=1.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the data memory responder.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Widths for the default 32-bit, 1024-word configuration. Parameterised
    // users derive their own from word_width and depth_words.
    localparam int unsigned DEF_WORD_WIDTH  = 32;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned DEF_STRB_W      = DEF_WORD_WIDTH / 8;
    localparam int unsigned DEF_IDX_W       = $clog2(DEF_DEPTH_WORDS);

    // Request error: not word aligned, or the base-relative offset falls
    // outside the array. off is the wrapped (word_width-bit) difference,
    // zero-extended, so addresses below base_addr wrap high and fail.
    function automatic logic addr_err(input logic [1:0]  addr_lo,
                                      input logic [63:0] off,
                                      input logic [63:0] span_bytes);
        return (addr_lo != 2'b00) || (off >= span_bytes);
    endfunction

endpackage

// File: rtl/byte_strobe_ram.sv
// Word array with byte-strobed synchronous write and registered read.
module byte_strobe_ram
    import mem_if_pkg::*;
#(
    parameter int unsigned word_width  = 32,
    parameter int unsigned depth_words = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(depth_words)-1:0] widx,
    input  logic [word_width-1:0]          wdata,
    input  logic [word_width/8-1:0]        wstrb,
    input  logic                           re,
    input  logic [$clog2(depth_words)-1:0] ridx,
    output logic [word_width-1:0]          rdata
);

    localparam int unsigned STRB_W = word_width / 8;

    logic [word_width-1:0] mem [depth_words];

    // Write enabled bytes and capture the read word; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[ridx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: handshake front end over a byte-strobed word array
// with a configurable read latency.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned          word_width   = 32,
    parameter int unsigned          depth_words  = 1024,
    parameter int unsigned          read_latency = 2,
    parameter logic [word_width-1:0] base_addr   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [word_width-1:0]   req_addr,
    input  logic [word_width-1:0]   req_wdata,
    input  logic [word_width/8-1:0] req_wstrb,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [word_width-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned IDX_W = $clog2(depth_words);
    localparam int unsigned CNT_W = $clog2(read_latency + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(read_latency - 1);
    localparam logic [63:0]      SPAN     = 64'(depth_words) * 64'd4;

    mem_state_t            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  ld_q, ld_d;
    logic                  err_q, err_d;

    logic [word_width-1:0] off;
    logic                  req_err;
    logic                  accept;
    logic [IDX_W-1:0]      idx;
    logic [word_width-1:0] ram_rdata;

    assign off     = req_addr - base_addr;
    assign req_err = addr_err(req_addr[1:0], 64'(off), SPAN);
    assign idx     = off[IDX_W+1:2];
    assign accept  = req_valid && req_ready;

    byte_strobe_ram #(
        .word_width  (word_width),
        .depth_words (depth_words)
    ) u_ram (
        .clk   (clk),
        .we    (accept && req_we && !req_err),
        .widx  (idx),
        .wdata (req_wdata),
        .wstrb (req_wstrb),
        .re    (accept && !req_we && !req_err),
        .ridx  (idx),
        .rdata (ram_rdata)
    );

    // Responder state, latency counter and response kind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ld_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ld_q  <= ld_d;
            err_q <= err_d;
        end
    end

    // Next state: an accepted request (from IDLE or RESP) overrides the
    // natural progression, which gives back-to-back issue out of RESP.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ld_d    = ld_q;
        err_d   = err_q;
        case (state)
            WAIT: begin
                if (cnt == CNT_ONE) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = state;
        endcase
        if (accept) begin
            err_d = req_err;
            ld_d  = !req_we && !req_err;
            if (req_err || req_we || read_latency == 1) begin
                state_d = RESP;
                cnt_d   = '0;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    // Outputs derive from registered state only; data and error are forced
    // to zero outside the response cycle.
    assign req_ready = (state != WAIT);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && ld_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (latency 2 / base 0, latency 3 /
// base 0x8000, latency 1 / base 0) driven by directed requests.
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    exp_t q0[$], q1[$], q2[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stalls = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .word_width   (32),
            .depth_words  (1024),
            .read_latency (g == 0 ? 2 : (g == 1 ? 3 : 1)),
            .base_addr    (g == 1 ? 32'h8000 : 32'h0)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req_valid (req_valid[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .req_ready (req_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Drive one request and wait for its acceptance edge; the expected
    // response is queued with the cycle count at which it must appear.
    task automatic issue(input int d, input string nm, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rd,
                         input logic exp_err, input bit push = 1'b1);
        int   waited;
        exp_t e;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = strb;
        waited = 0;
        while (!req_ready[d] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept_timeout dut%0d: req_ready stuck at 0, expected 1", nm, d);
            req_valid[d] = 1'b0;
            return;
        end
        if (waited > 0) stalls++;
        if (push) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.name  = nm;
            e.cyc   = cyc + ((we || exp_err) ? 1 : lat_of(d));
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_q0_empty", q0.size(), 0);
        chk("drain_q1_empty", q1.size(), 0);
        chk("drain_q2_empty", q2.size(), 0);
    endtask

    // Monitor: compare each response pulse against the queued expectation,
    // and require zeroed data/error between pulses.
    task automatic mon(input int d);
        exp_t e;
        if (rst[d]) return;
        if (rsp_valid[d]) begin
            n_cmp++;
            if (qsize(d) == 0) begin
                n_bad++;
                $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 at cyc %0d, expected none",
                         d, cyc);
            end else begin
                case (d)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                if (rsp_rdata[d] !== e.rdata || rsp_err[d] !== e.err || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: got rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                             e.name, d, rsp_rdata[d], rsp_err[d], cyc, e.rdata, e.err, e.cyc);
                end
            end
        end else begin
            n_cmp++;
            if (rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_outputs dut%0d: got rdata=%h err=%b, expected 0/0",
                         d, rsp_rdata[d], rsp_err[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) mon(d);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_wstrb[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ready_dut%0d", d), 32'(req_ready[d]), 1);
            chk($sformatf("reset_valid_dut%0d", d), 32'(rsp_valid[d]), 0);
            chk($sformatf("reset_rdata_dut%0d", d), rsp_rdata[d], 0);
            chk($sformatf("reset_err_dut%0d", d), 32'(rsp_err[d]), 0);
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Reset while a latency-3 load is waiting: the response is dropped.
        issue(1, "rst_load", 1'b0, 32'h8000, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst[1]       = 1'b1;
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready[1]), 1);
        chk("post_rst_valid", 32'(rsp_valid[1]), 0);
        chk("post_rst_rdata", rsp_rdata[1], 0);
        chk("post_rst_err", 32'(rsp_err[1]), 0);
        repeat (5) @(negedge clk);

        // Latency-2 store then load, with req_ready low during WAIT.
        issue(0, "st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        issue(0, "ld_10", 1'b0, 32'h10, 0, 0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("ready_low_in_wait", 32'(req_ready[0]), 0);

        // Byte strobes merge into the stored word.
        issue(0, "st_20_full", 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
        issue(0, "st_20_strb5", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 1'b0);
        issue(0, "ld_20", 1'b0, 32'h20, 0, 0, 32'h11BB33DD, 1'b0);

        // Errors: misaligned load; out-of-range store must not alias word 0.
        issue(0, "ld_22_misalign", 1'b0, 32'h22, 0, 0, 0, 1'b1);
        issue(0, "st_0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 1'b0);
        issue(0, "st_1000_oor", 1'b1, 32'h1000, 32'h55555555, 4'hF, 0, 1'b1);
        issue(0, "ld_0_intact", 1'b0, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0);
        idle(0);
        drain();

        // Four stores back to back: one response per cycle, no stall.
        stalls = 0;
        issue(0, "b2b_st_40", 1'b1, 32'h40, 32'h1, 4'hF, 0, 1'b0);
        issue(0, "b2b_st_44", 1'b1, 32'h44, 32'h2, 4'hF, 0, 1'b0);
        issue(0, "b2b_st_48", 1'b1, 32'h48, 32'h3, 4'hF, 0, 1'b0);
        issue(0, "b2b_st_4c", 1'b1, 32'h4C, 32'h4, 4'hF, 0, 1'b0);
        chk("b2b_store_stalls", stalls, 0);
        issue(0, "ld_4c", 1'b0, 32'h4C, 0, 0, 32'h4, 1'b0);
        idle(0);
        drain();

        // Latency 1: alternating stores and loads at one per cycle,
        // including read-after-write and a zero-strobe store.
        stalls = 0;
        issue(2, "l1_st_0", 1'b1, 32'h0, 32'h1, 4'hF, 0, 1'b0);
        issue(2, "l1_ld_0", 1'b0, 32'h0, 0, 0, 32'h1, 1'b0);
        issue(2, "l1_st_4", 1'b1, 32'h4, 32'h2, 4'hF, 0, 1'b0);
        issue(2, "l1_ld_4", 1'b0, 32'h4, 0, 0, 32'h2, 1'b0);
        issue(2, "l1_st_0_nostrb", 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        issue(2, "l1_ld_0_again", 1'b0, 32'h0, 0, 0, 32'h1, 1'b0);
        chk("l1_alt_stalls", stalls, 0);
        idle(2);
        drain();

        // Base 0x8000, latency 3.
        issue(1, "base_st_8004", 1'b1, 32'h8004, 32'h12345678, 4'hF, 0, 1'b0);
        issue(1, "base_ld_8004", 1'b0, 32'h8004, 0, 0, 32'h12345678, 1'b0);
        issue(1, "base_ld_0004", 1'b0, 32'h0004, 0, 0, 0, 1'b1);
        issue(1, "base_ld_9000", 1'b0, 32'h9000, 0, 0, 0, 1'b1);
        issue(1, "base_st_8ffc", 1'b1, 32'h8FFC, 32'h0BADF00D, 4'hF, 0, 1'b0);
        issue(1, "base_ld_8ffc", 1'b0, 32'h8FFC, 0, 0, 32'h0BADF00D, 1'b0);
        idle(1);

        repeat (3) @(negedge clk);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
